// File: rtl/button_conditioner.sv
// Two-button front end for a stopwatch.
// Start:  synchronise, debounce, one-cycle pulse on press, toggles bRun.
// Record: synchronise, debounce, then a hold FSM that tells a short press
//         (pulse on release) from a long press (clear pulse at the hold limit,
//         which also stops the stopwatch).
// All outputs are registered. Reset is synchronous and active-high.

module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic nStartBtn,
    input  logic nRecordBtn,
    output logic fStartPulse,
    output logic fRecordPulse,
    output logic fClearPulse,
    output logic bRun
);

    // Channel indices into the per-channel vectors below.
    localparam int CH_START  = 0;
    localparam int CH_RECORD = 1;
    localparam int NUM_CH    = 2;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Hold counter only has to reach LONG_CYCLES-1; it parks there in LONG.
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } rec_state_t;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] press_edge;    // accepted level went 1 -> 0 last edge
    logic [NUM_CH-1:0] release_edge;  // accepted level went 0 -> 1 last edge

    rec_state_t        rec_state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;

    assign raw[CH_START]  = nStartBtn;
    assign raw[CH_RECORD] = nRecordBtn;

    // Identical synchroniser + debouncer for every button. The buttons are
    // active-low, so the released (idle) level is 1 everywhere.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic            s1_reg;
            logic            s2_reg;
            logic            stable_reg;
            logic            stable_d_reg;
            logic [DB_W-1:0] db_cnt_reg;

            // Synchronise the raw pin, then accept a new level only after it
            // has differed from the accepted one for DEBOUNCE_CYCLES cycles.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    s1_reg       <= 1'b1;
                    s2_reg       <= 1'b1;
                    stable_reg   <= 1'b1;
                    stable_d_reg <= 1'b1;
                    db_cnt_reg   <= '0;
                end else begin
                    s1_reg       <= raw[gi];
                    s2_reg       <= s1_reg;
                    stable_d_reg <= stable_reg;
                    if (s2_reg != stable_reg) begin
                        if (db_cnt_reg == DB_LAST) begin
                            stable_reg <= s2_reg;
                            db_cnt_reg <= '0;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + DB_W'(1);
                        end
                    end else begin
                        // Any bounce back to the accepted level restarts the count.
                        db_cnt_reg <= '0;
                    end
                end
            end

            assign press_edge[gi]   = stable_d_reg & ~stable_reg;
            assign release_edge[gi] = ~stable_d_reg & stable_reg;
        end
    endgenerate

    // Start: registered edge detect on the accepted press; release is ignored.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fStartPulse <= 1'b0;
        end else begin
            fStartPulse <= press_edge[CH_START];
        end
    end

    // Record hold FSM: short press pulses on release, long press pulses once
    // when the hold limit is hit and then waits silently for the release.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rec_state_reg <= IDLE;
            hold_cnt_reg  <= '0;
            fRecordPulse  <= 1'b0;
            fClearPulse   <= 1'b0;
        end else begin
            fRecordPulse <= 1'b0;
            fClearPulse  <= 1'b0;
            case (rec_state_reg)
                IDLE: begin
                    if (press_edge[CH_RECORD]) begin
                        rec_state_reg <= HELD;
                        hold_cnt_reg  <= '0;
                    end
                end
                HELD: begin
                    if (release_edge[CH_RECORD]) begin
                        // A release always wins over reaching the limit in the same cycle.
                        rec_state_reg <= IDLE;
                        hold_cnt_reg  <= '0;
                        fRecordPulse  <= 1'b1;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        rec_state_reg <= LONG;
                        fClearPulse   <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                LONG: begin
                    // Counter stays parked at the limit until the button is released.
                    if (release_edge[CH_RECORD]) begin
                        rec_state_reg <= IDLE;
                        hold_cnt_reg  <= '0;
                    end
                end
                default: begin
                    rec_state_reg <= IDLE;
                    hold_cnt_reg  <= '0;
                end
            endcase
        end
    end

    // Run/stop level: clear forces stop and beats a simultaneous start toggle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bRun <= 1'b0;
        end else if (fClearPulse) begin
            bRun <= 1'b0;
        end else if (fStartPulse) begin
            bRun <= ~bRun;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Edges are numbered from 1; outputs are sampled 1 ns after each rising edge,
// and "pulse at edge E" means the output was high in the cycle after edge E.

module tb_button_conditioner;

    logic Clk = 1'b0;
    logic Rst;
    logic nStartBtn;
    logic nRecordBtn;
    logic fStartPulse;
    logic fRecordPulse;
    logic fClearPulse;
    logic bRun;

    int n_checks = 0;
    int n_errors = 0;

    int edge_cnt = 0;
    int st_n, st_e, rec_n, rec_e, clr_n, clr_e, run_e, run_high;
    int width_viol = 0;
    logic st_prev = 1'b0, rec_prev = 1'b0, clr_prev = 1'b0, run_prev = 1'b0;
    int L, Lr;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .nStartBtn   (nStartBtn),
        .nRecordBtn  (nRecordBtn),
        .fStartPulse (fStartPulse),
        .fRecordPulse(fRecordPulse),
        .fClearPulse (fClearPulse),
        .bRun        (bRun)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clear_stats();
        st_n = 0; st_e = -1; rec_n = 0; rec_e = -1;
        clr_n = 0; clr_e = -1; run_e = -1; run_high = 0;
    endtask

    // Advance n edges, logging pulse counts/edges and any pulse wider than one cycle.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            edge_cnt++;
            if (fStartPulse)  begin st_n++;  st_e  = edge_cnt; end
            if (fRecordPulse) begin rec_n++; rec_e = edge_cnt; end
            if (fClearPulse)  begin clr_n++; clr_e = edge_cnt; end
            if (bRun) run_high++;
            if (bRun !== run_prev) begin run_e = edge_cnt; run_prev = bRun; end
            if ((fStartPulse && st_prev) || (fRecordPulse && rec_prev) || (fClearPulse && clr_prev))
                width_viol++;
            st_prev  = fStartPulse;
            rec_prev = fRecordPulse;
            clr_prev = fClearPulse;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, int'(fStartPulse), 0);
        check({tag, "_record"}, int'(fRecordPulse), 0);
        check({tag, "_clear"}, int'(fClearPulse), 0);
        check({tag, "_run"}, int'(bRun), 0);
    endtask

    initial begin
        Rst = 1'b1;
        nStartBtn = 1'b1;
        nRecordBtn = 1'b1;
        clear_stats();

        // Reset state
        run(2);
        check_all_zero("reset");
        Rst = 1'b0;
        run(7);                           // edge_cnt = 9

        // Clean press: first sampled low at edge 10
        nStartBtn = 1'b0;
        clear_stats();
        run(21);
        check("clean_start_count", st_n, 1);
        check("clean_start_edge", st_e, 16);
        check("clean_run_rise_edge", run_e, 17);
        check("clean_run_level", int'(bRun), 1);
        nStartBtn = 1'b1;
        clear_stats();
        run(12);
        check("start_release_no_pulse", st_n, 0);

        // Bounce: 2-cycle lows/highs for 12 cycles, then held low
        clear_stats();
        for (int i = 0; i < 6; i++) begin
            nStartBtn = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(2);
        end
        check("bounce_no_pulse", st_n, 0);
        L = edge_cnt + 1;
        nStartBtn = 1'b0;
        run(20);
        check("bounce_start_count", st_n, 1);
        check("bounce_start_edge", st_e, L + 6);
        check("bounce_run_toggled_off", int'(bRun), 0);
        nStartBtn = 1'b1;
        run(12);

        // Short record: 10 cycles low then release
        clear_stats();
        L = edge_cnt + 1;
        nRecordBtn = 1'b0;
        run(10);
        check("short_no_pulse_on_press", rec_n, 0);
        nRecordBtn = 1'b1;
        run(30);
        check("short_record_count", rec_n, 1);
        check("short_record_edge", rec_e, L + 16);
        check("short_clear_count", clr_n, 0);

        // Long record with bRun = 1
        nStartBtn = 1'b0; run(12); nStartBtn = 1'b1; run(12);
        check("long_pre_run", int'(bRun), 1);
        clear_stats();
        L = edge_cnt + 1;
        nRecordBtn = 1'b0;
        run(40);
        nRecordBtn = 1'b1;
        run(30);
        check("long_clear_count", clr_n, 1);
        check("long_clear_edge", clr_e, L + 26);
        check("long_run_fall_edge", run_e, L + 27);
        check("long_record_count", rec_n, 0);
        check("long_run_level", int'(bRun), 0);

        // Collision: start pulse lands on the clear pulse, bRun was 0
        clear_stats();
        Lr = edge_cnt + 1;
        nRecordBtn = 1'b0;
        run(20);
        nStartBtn = 1'b0;
        run(30);
        nStartBtn = 1'b1;
        nRecordBtn = 1'b1;
        run(20);
        check("coll_start_count", st_n, 1);
        check("coll_start_edge", st_e, Lr + 26);
        check("coll_clear_count", clr_n, 1);
        check("coll_clear_edge", clr_e, Lr + 26);
        check("coll_run_high_cycles", run_high, 0);
        check("coll_record_count", rec_n, 0);

        // Reset mid-debounce with bRun = 1
        nStartBtn = 1'b0; run(12); nStartBtn = 1'b1; run(12);
        check("rst_pre_run", int'(bRun), 1);
        L = edge_cnt + 1;
        nStartBtn = 1'b0;
        run(4);                           // debounce counter is 2 now
        clear_stats();
        Rst = 1'b1;
        run(1);                           // reset edge L+4
        check_all_zero("mid_reset");
        Rst = 1'b0;
        run(20);
        check("rst_start_count", st_n, 1);
        check("rst_start_edge", st_e, L + 11);
        check("rst_run_level", int'(bRun), 1);
        nStartBtn = 1'b1;
        run(12);

        check("pulse_width_violations", width_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the stable-level cycles needed to accept a button change (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 50_000_000, giving the debounced-hold cycles on Record that count as a long press (1 s).
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port nStartBtn, input, 1 bit: raw, asynchronous, bouncing Start button, active-low.
REQ-006 SHALL have port nRecordBtn, input, 1 bit: raw, asynchronous, bouncing Record button, active-low.
REQ-007 SHALL have port fStartPulse, output, 1 bit: one-cycle high on each accepted Start press.
REQ-008 SHALL have port fRecordPulse, output, 1 bit: one-cycle high on release after a short Record press.
REQ-009 SHALL have port fClearPulse, output, 1 bit: one-cycle high when a Record hold reaches LONG_CYCLES.
REQ-010 SHALL have port bRun, output, 1 bit: run/stop level for the downstream stopwatch; 1 = counting.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Per channel, a debounce counter SHALL increment each cycle while s2 differs from the accepted level "stable", and SHALL clear to 0 whenever s2 equals stable.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, stable SHALL take s2 and the counter SHALL clear, all in that same cycle.
REQ-014 Latency: if a raw input is first sampled low at edge N and held, stable SHALL change at edge N+DEBOUNCE_CYCLES+1, and any resulting pulse SHALL be high for the cycle following edge N+DEBOUNCE_CYCLES+2.
REQ-015 Any bounce back to the stable level before the count completes SHALL restart the count from 0, with no output activity.
REQ-016 fStartPulse SHALL be a registered edge detect: high for exactly one cycle after Start stable goes 1->0; Start release SHALL produce nothing.
REQ-017 Record SHALL use a hold FSM with states IDLE, HELD and LONG.
REQ-018 Record FSM, IDLE->HELD: on Record stable 1->0, clearing the hold counter.
REQ-019 Record FSM, HELD: the hold counter SHALL increment every cycle.
REQ-020 Record FSM, HELD->LONG: when the hold counter reaches LONG_CYCLES-1, with fClearPulse asserted for one cycle.
REQ-021 Record FSM, HELD->IDLE: on Record stable 0->1, with fRecordPulse asserted for one cycle.
REQ-022 Record FSM, LONG->IDLE: on Record stable 0->1, with no pulse.
REQ-023 A long press SHALL produce exactly one fClearPulse and no fRecordPulse.
REQ-024 The hold counter SHALL be wide enough for LONG_CYCLES-1 (ceil log2) and SHALL never wrap; it saturates in LONG.
REQ-025 bRun SHALL toggle on the cycle after fStartPulse.
REQ-026 bRun SHALL be forced to 0 on the cycle after fClearPulse.
REQ-027 If fStartPulse and fClearPulse are high in the same cycle, clear SHALL win and bRun becomes 0.
REQ-028 The Start and Record channels SHALL be fully independent; simultaneous presses SHALL give both channels' pulses in their normal cycles.
REQ-029 No output pulse SHALL ever exceed one cycle.

Reset
REQ-030 With Rst high at a rising edge, s1, s2 and stable SHALL be 1 (released) on both channels.
REQ-031 With Rst high at a rising edge, all counters SHALL be 0 and the Record FSM SHALL be IDLE.
REQ-032 With Rst high at a rising edge, fStartPulse, fRecordPulse, fClearPulse and bRun SHALL be 0.
REQ-033 Reset asserted mid-debounce or mid-hold SHALL discard that activity with no pulse.
REQ-034 A button still held when Rst deasserts SHALL be treated as a new press and accepted after a full debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, 20 ns clock)
REQ-035 Clean press: nStartBtn low from edge 10 -> fStartPulse high only in the cycle after edge 16; bRun 0->1 after edge 17.
REQ-036 Bounce: nStartBtn toggles every 2 cycles for 12 cycles, then held low -> no pulse during bouncing; exactly one fStartPulse 6 cycles after the last low transition.
REQ-037 Short record: nRecordBtn held low 10 cycles, then released -> no pulse on press; one fRecordPulse after release debounce; fClearPulse stays 0.
REQ-038 Long record with bRun=1: nRecordBtn held low 40 cycles -> one fClearPulse 20 cycles after stable press; bRun goes to 0; no fRecordPulse on release.
REQ-039 Collision: fStartPulse and fClearPulse aligned in the same cycle -> bRun=0.
REQ-040 Reset mid-operation: Rst pulsed 1 cycle while nStartBtn is mid-debounce (counter=2), button held -> no pulse from the old count; one fStartPulse exactly DEBOUNCE_CYCLES+3 cycles after Rst deasserts; all outputs 0 during reset.
